mem_port_sequencer: RTL and testbench
=====================================

MEM_PORT_SEQUENCER -- requirements
Module: mem_port_sequencer

Interface
REQ-001 Parameter: DW, 32, data and address width in bits.
REQ-002 Parameter: WAIT, 2, extra memory wait cycles per access; legal range 0..15.
REQ-003 clk  in  1  the block's single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 if_req  in  1  fetch request; held high until if_ack.
REQ-006 if_addr  in  DW  fetch address; held stable while if_req is high.
REQ-007 rmem  in  1  data read request from ControlUnit; held until d_ack.
REQ-008 wmem  in  1  data write request from ControlUnit; held until d_ack.
REQ-009 d_addr  in  DW  data address; stable while rmem or wmem is high.
REQ-010 d_wdata  in  DW  write data; stable while wmem is high.
REQ-011 mem_rdata  in  DW  memory read data; valid in the last cycle of an access.
REQ-012 mem_en  out  1  memory access active.
REQ-013 mem_we  out  1  memory write strobe.
REQ-014 mem_addr  out  DW  memory address.
REQ-015 mem_wdata  out  DW  memory write data.
REQ-016 if_ack  out  1  one-cycle fetch-done pulse.
REQ-017 if_rdata  out  DW  fetched instruction; registered.
REQ-018 d_ack  out  1  one-cycle data-done pulse.
REQ-019 d_rdata  out  DW  load data; registered.
REQ-020 stall  out  1  pipeline stall, high while any request is pending.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, IF_ACC and D_ACC.
REQ-022 Eligibility: d_req = rmem|wmem; a requester SHALL be ineligible in any cycle where its own ack is high.
REQ-023 IDLE SHALL go to D_ACC if d_req is eligible, else to IF_ACC if if_req is eligible; when both are eligible, the requester not named by last_grant SHALL win.
REQ-024 On entering an ACC state, the block SHALL latch address, write data and we = wmem; cnt SHALL load WAIT, and last_grant SHALL update.
REQ-025 In an ACC state, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL come from the latched values; cnt SHALL decrement each cycle, so one access lasts WAIT+1 cycles.
REQ-026 In the cycle where cnt==0, the block SHALL capture mem_rdata into if_rdata or d_rdata; writes SHALL leave d_rdata unchanged.
REQ-027 The matching ack SHALL be high in the next cycle only; latency from request-sampled edge to ack is WAIT+2 cycles.
REQ-028 At cnt==0, the next state SHALL be the other requester's ACC state if that requester is eligible, else IDLE; the just-served requester is masked, giving back-to-back operation with no IDLE gap.
REQ-029 If rmem and wmem are both high, the access SHALL be a write.
REQ-030 When not in an ACC state, mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-031 stall SHALL equal (if_req & ~if_ack) | (d_req & ~d_ack), combinationally.
REQ-032 A request that drops before it is granted SHALL be discarded; once an access is granted, it SHALL complete using the latched values.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, cnt 0, last_grant IF, acks 0, if_rdata 0, d_rdata 0, all mem_* outputs 0.
REQ-034 An access interrupted by reset SHALL NOT produce an ack; the requester re-requests after rst_n rises.
REQ-035 The first arbitration after reset with both requests pending SHALL grant data.

Verification (WAIT=2 unless noted)
REQ-036 if_req=1 at cycle 0, if_addr=0x10, mem_rdata=0xDEADBEEF -> mem_en high in cycles 1-3 with mem_addr=0x10; if_ack high in cycle 4; if_rdata=0xDEADBEEF.
REQ-037 if_req and rmem both high at cycle 0 -> data access in cycles 1-3, d_ack in cycle 4, fetch access in cycles 4-6, if_ack in cycle 7; stall high in cycles 0-6.
REQ-038 wmem=1, d_addr=0x20, d_wdata=0x55 -> mem_we=1 in cycles 1-3 with mem_wdata=0x55; d_ack in cycle 4; d_rdata unchanged.
REQ-039 Both requesters re-requesting continuously -> grants alternate D, IF, D, IF; no requester is granted twice in a row.
REQ-040 rst_n low in cycle 2 of a fetch -> mem_en=0 in the same cycle; no if_ack; the reissued fetch completes with normal latency.
REQ-041 WAIT=0, single rmem -> mem_en high for 1 cycle; d_ack 2 cycles after the request is sampled.

Source files
------------

// File: rtl/mem_port_sequencer.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// Each access takes WAIT+1 cycles, and the two requesters alternate when both are waiting.
module mem_port_sequencer #(
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [DW-1:0] if_addr,
    input  logic          rmem,
    input  logic          wmem,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          stall,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2
    } state_t;

    localparam logic       GRANT_IF = 1'b0;
    localparam logic       GRANT_D  = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic          last_grant;
    logic [DW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;

    logic d_req;
    logic if_elig;
    logic d_elig;
    logic load_if;
    logic load_d;
    logic acc_done;

    // Valid/ready: a request is held until its ack pulse; the ack cycle masks it
    // so a still-high request is not mistaken for a new one.
    always_comb begin
        d_req     = rmem | wmem;
        if_elig   = if_req & ~if_ack;
        d_elig    = d_req & ~d_ack;
        acc_done  = (state != IDLE) && (cnt == 4'd0);
        load_if   = 1'b0;
        load_d    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_elig && (!if_elig || last_grant == GRANT_IF)) begin
                    load_d = 1'b1;
                end else if (if_elig) begin
                    load_if = 1'b1;
                end
            end
            IF_ACC: begin
                if (acc_done) begin
                    if (d_elig) begin
                        load_d = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            D_ACC: begin
                if (acc_done) begin
                    if (if_elig) begin
                        load_if = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load_d) begin
            state_nxt = D_ACC;
        end else if (load_if) begin
            state_nxt = IF_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= GRANT_IF;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state  <= state_nxt;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if (acc_done && state == IF_ACC) begin
                if_rdata <= mem_rdata;
                if_ack   <= 1'b1;
            end
            if (acc_done && state == D_ACC) begin
                if (!lat_we) begin
                    d_rdata <= mem_rdata;
                end
                d_ack <= 1'b1;
            end
            // A new grant reloads everything; otherwise count down the access.
            if (load_if) begin
                lat_addr   <= if_addr;
                lat_wdata  <= '0;
                lat_we     <= 1'b0;
                cnt        <= CNT_LOAD;
                last_grant <= GRANT_IF;
            end else if (load_d) begin
                lat_addr   <= d_addr;
                lat_wdata  <= d_wdata;
                lat_we     <= wmem;
                cnt        <= CNT_LOAD;
                last_grant <= GRANT_D;
            end else if (state != IDLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Memory outputs are gated by state so they drop to zero the moment reset hits.
    always_comb begin
        mem_en    = (state != IDLE);
        mem_we    = mem_en & lat_we;
        mem_addr  = mem_en ? lat_addr : '0;
        mem_wdata = mem_en ? lat_wdata : '0;
        stall     = if_elig | d_elig;
        state_dbg = state;
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: cycle tables for single and contended
// accesses, plus hand-written sequences for alternation, mid-access reset and WAIT=0.
module tb_mem_port_sequencer;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic          rmem;
    logic          wmem;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mem_rdata;

    logic          mem_en, mem_we, if_ack, d_ack, stall;
    logic [DW-1:0] mem_addr, mem_wdata, if_rdata, d_rdata;
    logic [1:0]    state_dbg;

    logic          mem_en0, mem_we0, if_ack0, d_ack0, stall0;
    logic [DW-1:0] mem_addr0, mem_wdata0, if_rdata0, d_rdata0;
    logic [1:0]    state_dbg0;

    int total = 0;
    int bad   = 0;

    mem_port_sequencer #(.DW(DW), .WAIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
        .rmem(rmem), .wmem(wmem), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .if_ack(if_ack),
        .if_rdata(if_rdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .stall(stall), .state_dbg(state_dbg)
    );

    mem_port_sequencer #(.DW(DW), .WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
        .rmem(rmem), .wmem(wmem), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_en(mem_en0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .if_ack(if_ack0),
        .if_rdata(if_rdata0), .d_ack(d_ack0), .d_rdata(d_rdata0),
        .stall(stall0), .state_dbg(state_dbg0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          ifr;
        logic [DW-1:0] ia;
        logic          rm;
        logic          wm;
        logic [DW-1:0] da;
        logic [DW-1:0] wd;
        logic [DW-1:0] mr;
        logic          en;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdat;
        logic          ifack;
        logic          dack;
        logic          stl;
        logic [DW-1:0] ifrd;
        logic [DW-1:0] drd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ifr, input logic [DW-1:0] ia, input logic rm,
                       input logic wm, input logic [DW-1:0] da, input logic [DW-1:0] wd,
                       input logic [DW-1:0] mr, input logic en, input logic we,
                       input logic [DW-1:0] addr, input logic [DW-1:0] wdat,
                       input logic ifack, input logic dack, input logic stl,
                       input logic [DW-1:0] ifrd, input logic [DW-1:0] drd);
        vec_t v;
        v.ifr = ifr; v.ia = ia; v.rm = rm; v.wm = wm; v.da = da; v.wd = wd; v.mr = mr;
        v.en = en; v.we = we; v.addr = addr; v.wdat = wdat;
        v.ifack = ifack; v.dack = dack; v.stl = stl; v.ifrd = ifrd; v.drd = drd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0; rmem = 1'b0; wmem = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    localparam logic [DW-1:0] VA = 32'hAAAA_0001;
    localparam logic [DW-1:0] VB = 32'hBBBB_0002;
    localparam logic [DW-1:0] VD = 32'hDEAD_BEEF;

    initial begin
        string nm;
        logic [DW-1:0] exp_addr;
        int n;
        bit found;

        rst_n = 1'b0;
        drive_idle();

        // contended fetch+load: data wins first after reset, fetch follows with no gap
        add(1, 'h10, 1, 0, 'h20, 0, 'h111, 0, 0, 0,     0, 0, 0, 1, 0,  0);
        add(1, 'h10, 1, 0, 'h20, 0, 'h222, 1, 0, 'h20,  0, 0, 0, 1, 0,  0);
        add(1, 'h10, 1, 0, 'h20, 0, 'h333, 1, 0, 'h20,  0, 0, 0, 1, 0,  0);
        add(1, 'h10, 1, 0, 'h20, 0, VA,    1, 0, 'h20,  0, 0, 0, 1, 0,  0);
        add(1, 'h10, 1, 0, 'h20, 0, 'h444, 1, 0, 'h10,  0, 0, 1, 1, 0,  VA);
        add(1, 'h10, 0, 0, 'h20, 0, 'h555, 1, 0, 'h10,  0, 0, 0, 1, 0,  VA);
        add(1, 'h10, 0, 0, 'h20, 0, VB,    1, 0, 'h10,  0, 0, 0, 1, 0,  VA);
        add(1, 'h10, 0, 0, 'h20, 0, 'h666, 0, 0, 0,     0, 1, 0, 0, VB, VA);
        add(0, 'h10, 0, 0, 'h20, 0, 'h777, 0, 0, 0,     0, 0, 0, 0, VB, VA);
        // single fetch
        add(1, 'h10, 0, 0, 0, 0, 'h1, 0, 0, 0,    0, 0, 0, 1, VB, VA);
        add(1, 'h10, 0, 0, 0, 0, 'h2, 1, 0, 'h10, 0, 0, 0, 1, VB, VA);
        add(1, 'h10, 0, 0, 0, 0, 'h3, 1, 0, 'h10, 0, 0, 0, 1, VB, VA);
        add(1, 'h10, 0, 0, 0, 0, VD,  1, 0, 'h10, 0, 0, 0, 1, VB, VA);
        add(1, 'h10, 0, 0, 0, 0, 'h4, 0, 0, 0,    0, 1, 0, 0, VD, VA);
        add(0, 'h10, 0, 0, 0, 0, 'h5, 0, 0, 0,    0, 0, 0, 0, VD, VA);
        // single write: d_rdata must hold its old value
        add(0, 0, 0, 1, 'h20, 'h55, 'h6,    0, 0, 0,    0,    0, 0, 1, VD, VA);
        add(0, 0, 0, 1, 'h20, 'h55, 'h7,    1, 1, 'h20, 'h55, 0, 0, 1, VD, VA);
        add(0, 0, 0, 1, 'h20, 'h55, 'h8,    1, 1, 'h20, 'h55, 0, 0, 1, VD, VA);
        add(0, 0, 0, 1, 'h20, 'h55, 'hCAFE, 1, 1, 'h20, 'h55, 0, 0, 1, VD, VA);
        add(0, 0, 0, 1, 'h20, 'h55, 'h9,    0, 0, 0,    0,    0, 1, 0, VD, VA);
        add(0, 0, 0, 0, 'h20, 'h55, 'ha,    0, 0, 0,    0,    0, 0, 0, VD, VA);
        // rmem and wmem together: treated as a write
        add(0, 0, 1, 1, 'h30, 'h77, 'hb,    0, 0, 0,    0,    0, 0, 1, VD, VA);
        add(0, 0, 1, 1, 'h30, 'h77, 'hc,    1, 1, 'h30, 'h77, 0, 0, 1, VD, VA);
        add(0, 0, 1, 1, 'h30, 'h77, 'hd,    1, 1, 'h30, 'h77, 0, 0, 1, VD, VA);
        add(0, 0, 1, 1, 'h30, 'h77, 'hBEEF, 1, 1, 'h30, 'h77, 0, 0, 1, VD, VA);
        add(0, 0, 1, 1, 'h30, 'h77, 'he,    0, 0, 0,    0,    0, 1, 0, VD, VA);
        add(0, 0, 0, 0, 'h30, 'h77, 'hf,    0, 0, 0,    0,    0, 0, 0, VD, VA);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_state", state_dbg, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            if_req = vecs[i].ifr; if_addr = vecs[i].ia; rmem = vecs[i].rm; wmem = vecs[i].wm;
            d_addr = vecs[i].da; d_wdata = vecs[i].wd; mem_rdata = vecs[i].mr;
            @(negedge clk);
            nm = $sformatf("v%0d", i);
            chk({nm, "_mem_en"}, mem_en, vecs[i].en);
            chk({nm, "_mem_we"}, mem_we, vecs[i].we);
            chk({nm, "_mem_addr"}, mem_addr, vecs[i].addr);
            chk({nm, "_mem_wdata"}, mem_wdata, vecs[i].wdat);
            chk({nm, "_if_ack"}, if_ack, vecs[i].ifack);
            chk({nm, "_d_ack"}, d_ack, vecs[i].dack);
            chk({nm, "_stall"}, stall, vecs[i].stl);
            chk({nm, "_if_rdata"}, if_rdata, vecs[i].ifrd);
            chk({nm, "_d_rdata"}, d_rdata, vecs[i].drd);
        end

        // continuous contention: grants alternate D, IF, D, ... with no idle gap
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 'h10; rmem = 1'b1; d_addr = 'h20;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("alt_c%0d_mem_en", c), mem_en, 1);
            if ((c - 1) % 3 == 0) begin
                exp_addr = (((c - 1) / 3) % 2 == 0) ? 32'h20 : 32'h10;
                chk($sformatf("alt_grant%0d_addr", (c - 1) / 3), mem_addr, exp_addr);
            end
        end
        drive_idle();

        // reset in cycle 2 of a fetch: outputs drop at once, no ack, reissue completes
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 'h10; mem_rdata = 32'h1357_9bdf;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_c1_mem_en", mem_en, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_same_cycle_mem_en", mem_en, 0);
        chk("rstmid_same_cycle_addr", mem_addr, 0);
        @(negedge clk);
        chk("rstmid_no_ack_a", if_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_no_ack_b", if_ack, 0);
        chk("rstmid_if_rdata", if_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_no_ack_c", if_ack, 0);
        found = 1'b0;
        n = 0;
        while (!found && n < 10) begin
            @(negedge clk);
            n++;
            if (if_ack) found = 1'b1;
        end
        chk("rstmid_reissue_ack_seen", found, 1);
        chk("rstmid_reissue_latency", n, 4);
        chk("rstmid_reissue_rdata", if_rdata, 32'h1357_9bdf);
        @(posedge clk); #1;
        drive_idle();

        // WAIT=0 instance: one-cycle access, ack two cycles after sampling
        do_reset();
        @(posedge clk); #1;
        rmem = 1'b1; d_addr = 'h40; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("w0_c0_mem_en", mem_en0, 0);
        chk("w0_c0_stall", stall0, 1);
        @(posedge clk); #1;
        mem_rdata = 32'h9999_0041;
        @(negedge clk);
        chk("w0_c1_mem_en", mem_en0, 1);
        chk("w0_c1_mem_addr", mem_addr0, 'h40);
        chk("w0_c1_d_ack", d_ack0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w0_c2_mem_en", mem_en0, 0);
        chk("w0_c2_d_ack", d_ack0, 1);
        chk("w0_c2_d_rdata", d_rdata0, 32'h9999_0041);
        chk("w0_c2_stall", stall0, 0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("w0_c3_d_ack", d_ack0, 0);
        chk("w0_c3_mem_en", mem_en0, 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
